// File: rtl/fp_mult.sv
// Multi-cycle IEEE-754 single-precision multiplier with a start/busy/done/serv handshake.
// The mantissa product is built by an iterative shift-add, then normalized and rounded to nearest-even.
module fp_mult #(
   parameter int unsigned BITS_PER_CYCLE = 1,
   parameter int unsigned BIAS           = 127
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   input  logic        mul_start,
   input  logic        mul_serv,
   output logic [31:0] mul_result,
   output logic        mul_done,
   output logic        mul_overflow,
   output logic        mul_busy
);

   localparam int unsigned MULT_CYCLES = 24 / BITS_PER_CYCLE;
   localparam logic [4:0]  LAST_CYCLE  = 5'(MULT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      UNPACK,
      MULT,
      NORM,
      ROUND,
      DONE
   } state_t;

   state_t state, state_next;

   logic [31:0]       a_op, b_op;
   logic              sign;
   logic signed [9:0] exp_r;
   logic [47:0]       mcand;
   logic [23:0]       mplier;
   logic [47:0]       acc;
   logic [4:0]        count;
   logic [22:0]       mant_n;
   logic              guard, sticky;

   // Operand decode for the UNPACK step
   logic [7:0]        ea, eb;
   logic              a_zero, b_zero, a_inf, b_inf;
   logic              special, special_ovf, sign_in;
   logic [31:0]       special_res;
   logic signed [9:0] exp_sum;

   always_comb begin
      ea          = a_op[30:23];
      eb          = b_op[30:23];
      a_zero      = (ea == 8'h00);
      b_zero      = (eb == 8'h00);
      a_inf       = (ea == 8'hFF);
      b_inf       = (eb == 8'hFF);
      sign_in     = a_op[31] ^ b_op[31];
      special     = a_zero | b_zero | a_inf | b_inf;
      special_ovf = a_inf | b_inf;
      if (a_inf || b_inf)
         special_res = (a_zero || b_zero) ? 32'h7FC00000 : {sign_in, 8'hFF, 23'h0};
      else
         special_res = {sign_in, 31'h0};
      exp_sum = {2'b00, ea} + {2'b00, eb} - 10'(BIAS);
   end

   // One shift-add step retires BITS_PER_CYCLE multiplier bits
   logic [BITS_PER_CYCLE-1:0] digit;
   logic [47:0]               partial;

   always_comb begin
      digit   = mplier[BITS_PER_CYCLE-1:0];
      partial = '0;
      for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
         if (digit[0])
            partial = partial + (mcand << i);
         digit = digit >> 1;
      end
   end

   // Round-to-nearest-even with renormalization on mantissa carry-out
   logic              round_up;
   logic [23:0]       mant_sum;
   logic signed [9:0] exp_fin;
   logic [31:0]       round_res;
   logic              round_ovf;

   always_comb begin
      round_up  = guard & (sticky | mant_n[0]);
      mant_sum  = {1'b0, mant_n} + {23'b0, round_up};
      exp_fin   = mant_sum[23] ? exp_r + 10'sd1 : exp_r;
      round_ovf = 1'b0;
      if (exp_fin >= 10'sd255) begin
         round_res = {sign, 8'hFF, 23'h0};
         round_ovf = 1'b1;
      end else if (exp_fin <= 10'sd0) begin
         round_res = {sign, 31'h0};
      end else begin
         round_res = {sign, exp_fin[7:0], mant_sum[22:0]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (mul_start) state_next = UNPACK;
         UNPACK:  state_next = special ? DONE : MULT;
         MULT:    if (count == LAST_CYCLE) state_next = NORM;
         NORM:    state_next = ROUND;
         ROUND:   state_next = DONE;
         DONE:    if (mul_serv) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_op         <= '0;
         b_op         <= '0;
         sign         <= 1'b0;
         exp_r        <= '0;
         mcand        <= '0;
         mplier       <= '0;
         acc          <= '0;
         count        <= '0;
         mant_n       <= '0;
         guard        <= 1'b0;
         sticky       <= 1'b0;
         mul_result   <= '0;
         mul_done     <= 1'b0;
         mul_overflow <= 1'b0;
         mul_busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mul_start) begin
                  a_op     <= op1;
                  b_op     <= op2;
                  mul_busy <= 1'b1;
               end
            end
            UNPACK: begin
               sign <= sign_in;
               if (special) begin
                  mul_result   <= special_res;
                  mul_overflow <= special_ovf;
                  mul_done     <= 1'b1;
               end else begin
                  exp_r  <= exp_sum;
                  mcand  <= {24'b0, 1'b1, a_op[22:0]};
                  mplier <= {1'b1, b_op[22:0]};
                  acc    <= '0;
                  count  <= '0;
               end
            end
            MULT: begin
               acc    <= acc + partial;
               mcand  <= mcand << BITS_PER_CYCLE;
               mplier <= mplier >> BITS_PER_CYCLE;
               count  <= count + 5'd1;
            end
            NORM: begin
               // Product lies in [1,4); bit 47 marks the [2,4) half
               if (acc[47]) begin
                  mant_n <= acc[46:24];
                  guard  <= acc[23];
                  sticky <= |acc[22:0];
                  exp_r  <= exp_r + 10'sd1;
               end else begin
                  mant_n <= acc[45:23];
                  guard  <= acc[22];
                  sticky <= |acc[21:0];
               end
            end
            ROUND: begin
               mul_result   <= round_res;
               mul_overflow <= round_ovf;
               mul_done     <= 1'b1;
            end
            DONE: begin
               if (mul_serv) begin
                  mul_done <= 1'b0;
                  mul_busy <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_mult.sv
// Bench for fp_mult: directed cases plus random operands against an integer-arithmetic reference.
module tb_fp_mult;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic        start1 = 1'b0, serv1 = 1'b0;
   logic        start4 = 1'b0, serv4 = 1'b0;
   logic [31:0] result1, result4;
   logic        done1, done4, ovf1, ovf4, busy1, busy4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fp_mult #(.BITS_PER_CYCLE(1)) dut (
      .clk(clk), .rst(rst), .op1(op1), .op2(op2),
      .mul_start(start1), .mul_serv(serv1),
      .mul_result(result1), .mul_done(done1),
      .mul_overflow(ovf1), .mul_busy(busy1)
   );

   fp_mult #(.BITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst(rst), .op1(op1), .op2(op2),
      .mul_start(start4), .mul_serv(serv4),
      .mul_result(result4), .mul_done(done4),
      .mul_overflow(ovf4), .mul_busy(busy4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
      return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
             (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
   endfunction

   // Returns {overflow, result}: exact integer product, then RNE on the remainder
   function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic s;
      int ea, eb, e, sh;
      longint unsigned p, q, rem, half;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if (ea == 255 || eb == 255)
         return (ea == 0 || eb == 0) ? {1'b1, 32'h7FC00000} : {1'b1, s, 8'hFF, 23'h0};
      if (ea == 0 || eb == 0)
         return {1'b0, s, 31'h0};
      p  = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
      e  = ea + eb - 127;
      sh = 23;
      if (p >= (64'd1 << 47)) begin
         sh = 24;
         e++;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0]))
         q++;
      if (q == (64'd1 << 24)) begin
         q = 64'd1 << 23;
         e++;
      end
      if (e >= 255)
         return {1'b1, s, 8'hFF, 23'h0};
      if (e <= 0)
         return {1'b0, s, 31'h0};
      return {1'b0, s, 8'(e), 23'(q)};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] r;
      logic [7:0]  e;
      r = $urandom;
      case ($urandom_range(0, 7))
         0: case ($urandom_range(0, 3))
               0:       e = 8'h00;
               1:       e = 8'hFF;
               2:       e = 8'h01;
               default: e = 8'hFE;
            endcase
         1:       e = 8'($urandom_range(185, 200));
         2:       e = 8'($urandom_range(30, 70));
         default: e = 8'($urandom_range(100, 154));
      endcase
      r[30:23] = e;
      if ($urandom_range(0, 7) == 0)
         r[22:0] = '1;
      return r;
   endfunction

   task automatic do_op(input bit use4, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [32:0] m;
      int lat, edges;
      bit busy_ok;
      m   = ref_mul(a, b);
      lat = is_special(a, b) ? 1 : 3 + 24 / (use4 ? 4 : 1);
      op1 = a;
      op2 = b;
      if (use4) start4 = 1'b1;
      else      start1 = 1'b1;
      tick();
      start1  = 1'b0;
      start4  = 1'b0;
      edges   = 0;
      busy_ok = 1'b1;
      while (((use4 ? done4 : done1) !== 1'b1) && edges < 200) begin
         if ((use4 ? busy4 : busy1) !== 1'b1) busy_ok = 1'b0;
         tick();
         edges++;
      end
      check({tag, " latency"}, 32'(edges), 32'(lat));
      check({tag, " busy"}, 32'(busy_ok && ((use4 ? busy4 : busy1) === 1'b1)), 32'd1);
      check({tag, " result"}, use4 ? result4 : result1, m[31:0]);
      check({tag, " overflow"}, 32'(use4 ? ovf4 : ovf1), 32'(m[32]));
      if (use4) serv4 = 1'b1;
      else      serv1 = 1'b1;
      tick();
      serv1 = 1'b0;
      serv4 = 1'b0;
      check({tag, " release"}, use4 ? 32'({done4, busy4}) : 32'({done1, busy1}), 32'd0);
      check({tag, " hold"}, use4 ? result4 : result1, m[31:0]);
   endtask

   initial begin
      int  e;
      bit  hold_ok;

      tick();
      tick();
      check("reset result", result1, 32'h0);
      check("reset flags", 32'({done1, ovf1, busy1}), 32'd0);
      rst = 1'b0;
      tick();

      do_op(1'b0, 32'h3FC00000, 32'h40000000, "c1");
      check("c1 const", result1, 32'h40400000);
      do_op(1'b0, 32'hC0200000, 32'h40800000, "c2a");
      check("c2a const", result1, 32'hC1200000);
      do_op(1'b0, 32'h3F800001, 32'h3F800001, "c2b");
      check("c2b const", result1, 32'h3F800002);
      do_op(1'b0, 32'h00000000, 32'hC0A00000, "c3a");
      check("c3a const", result1, 32'h80000000);
      do_op(1'b0, 32'h00800000, 32'h00800000, "c3b");
      check("c3b const", {ovf1, result1[30:0]}, 32'h0);
      do_op(1'b0, 32'h7F000000, 32'h7F000000, "c4a");
      check("c4a const", result1, 32'h7F800000);
      check("c4a ovf", 32'(ovf1), 32'd1);
      do_op(1'b0, 32'h7F800000, 32'h00000000, "c4b");
      check("c4b const", result1, 32'h7FC00000);
      check("c4b ovf", 32'(ovf1), 32'd1);

      // second start mid-MULT must be ignored
      op1 = 32'h3FC00000;
      op2 = 32'h40000000;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      e = 0;
      while (done1 !== 1'b1 && e < 200) begin
         if (e == 5) begin
            op1 = 32'hC0200000;
            op2 = 32'h40800000;
            start1 = 1'b1;
         end else begin
            start1 = 1'b0;
         end
         tick();
         e++;
      end
      start1 = 1'b0;
      check("c5 latency", 32'(e), 32'd27);
      check("c5 result", result1, 32'h40400000);
      hold_ok = 1'b1;
      repeat (10) begin
         tick();
         if (done1 !== 1'b1 || result1 !== 32'h40400000) hold_ok = 1'b0;
      end
      check("c5 done held", 32'(hold_ok), 32'd1);
      op1 = 32'h7F000000;
      op2 = 32'h7F000000;
      start1 = 1'b1;
      serv1  = 1'b1;
      tick();
      start1 = 1'b0;
      serv1  = 1'b0;
      check("c5 serv+start release", 32'({done1, busy1}), 32'd0);
      repeat (3) tick();
      check("c5 no new op", 32'({done1, busy1, ovf1}), 32'd0);
      check("c5 result kept", result1, 32'h40400000);

      // asynchronous reset mid-MULT
      op1 = 32'h3FC00000;
      op2 = 32'h40000000;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      #1;
      check("c6 async flags", 32'({busy1, done1, ovf1}), 32'd0);
      check("c6 async result", result1, 32'h0);
      tick();
      rst = 1'b0;
      tick();
      do_op(1'b0, 32'h3FC00000, 32'h40000000, "c6 rerun");
      check("c6 rerun const", result1, 32'h40400000);
      do_op(1'b1, 32'h3FC00000, 32'h40000000, "c6 bpc4");
      check("c6 bpc4 const", result4, 32'h40400000);

      for (int k = 0; k < 40; k++)
         do_op(1'b0, rand_op(), rand_op(), $sformatf("rnd1_%0d", k));
      for (int k = 0; k < 15; k++)
         do_op(1'b1, rand_op(), rand_op(), $sformatf("rnd4_%0d", k));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
